// File: rtl/exec_regs_dmem_if.sv
// Bus between decode/control and the execute/storage slice of the 8-bit datapath.
// The control unit is the master; the datapath slice is the slave.
interface exec_regs_dmem_if;
    logic       reg_write_en;
    logic [2:0] reg_write_dest;
    logic [2:0] reg_read_addr_1;
    logic [2:0] reg_read_addr_2;
    logic [7:0] reg_read_data_1;
    logic [7:0] reg_read_data_2;
    logic       alu_src;
    logic [7:0] imm;
    logic [2:0] alu_control;
    logic [7:0] alu_result;
    logic       zero;
    logic       mem_write;
    logic       mem_read;
    logic [7:0] mem_read_data;
    logic [7:0] reg_write_data;
    logic       mem_to_reg;

    modport master (
        output reg_write_en, reg_write_dest, reg_read_addr_1, reg_read_addr_2,
               alu_src, imm, alu_control, mem_write, mem_read, mem_to_reg,
        input  reg_read_data_1, reg_read_data_2, alu_result, zero,
               mem_read_data, reg_write_data
    );

    modport slave (
        input  reg_write_en, reg_write_dest, reg_read_addr_1, reg_read_addr_2,
               alu_src, imm, alu_control, mem_write, mem_read, mem_to_reg,
        output reg_read_data_1, reg_read_data_2, alu_result, zero,
               mem_read_data, reg_write_data
    );
endinterface

// File: rtl/exec_regs_dmem.sv
// Execute/storage slice: 8x8 register file, 8-bit ALU and data memory.
// All reads and outputs are combinational; register and memory writes commit on the clock edge.
module exec_regs_dmem #(
    parameter int DMEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    exec_regs_dmem_if.slave   bus
);
    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [7:0]    regs_q [8];
    logic [7:0]    mem_q  [DMEM_DEPTH];
    logic [7:0]    rd1;
    logic [7:0]    rd2;
    logic [7:0]    alu_b;
    logic [7:0]    alu_res;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic [7:0]    wb_data;

    assign rd1 = regs_q[bus.reg_read_addr_1];
    assign rd2 = regs_q[bus.reg_read_addr_2];

    always_comb begin
        alu_b   = bus.alu_src ? bus.imm : rd2;
        alu_res = 8'h00;
        case (bus.alu_control)
            3'b000: alu_res = rd1 + alu_b;
            3'b001: alu_res = rd1 - alu_b;
            3'b010: alu_res = ~rd1;
            3'b011: alu_res = (alu_b >= 8'd8) ? 8'h00 : (rd1 << alu_b[2:0]);
            3'b100: alu_res = (alu_b >= 8'd8) ? 8'h00 : (rd1 >> alu_b[2:0]);
            3'b101: alu_res = rd1 & alu_b;
            3'b110: alu_res = rd1 | alu_b;
            3'b111: alu_res = (rd1 < alu_b) ? 8'h01 : 8'h00;
            default: alu_res = 8'h00;
        endcase
    end

    // Upper address bits are dropped, so addresses alias modulo DMEM_DEPTH.
    assign mem_addr  = alu_res[AW-1:0];
    assign mem_rdata = bus.mem_read ? mem_q[mem_addr] : 8'h00;
    assign wb_data   = bus.mem_to_reg ? mem_rdata : alu_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
        end else if (bus.reg_write_en) begin
            regs_q[bus.reg_write_dest] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (bus.mem_write) begin
            mem_q[mem_addr] <= rd2;
        end
    end

    assign bus.reg_read_data_1 = rd1;
    assign bus.reg_read_data_2 = rd2;
    assign bus.alu_result      = alu_res;
    assign bus.zero            = (alu_res == 8'h00);
    assign bus.mem_read_data   = mem_rdata;
    assign bus.reg_write_data  = wb_data;
endmodule

// File: tb/tb_exec_regs_dmem.sv
// Directed bench for exec_regs_dmem: reset, register writes, ALU ops, memory and no-bypass behaviour.
module tb_exec_regs_dmem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    exec_regs_dmem_if bus ();

    exec_regs_dmem #(.DMEM_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.reg_write_en    = 1'b0;
        bus.reg_write_dest  = 3'd0;
        bus.reg_read_addr_1 = 3'd0;
        bus.reg_read_addr_2 = 3'd0;
        bus.alu_src         = 1'b0;
        bus.imm             = 8'h00;
        bus.alu_control     = 3'b000;
        bus.mem_write       = 1'b0;
        bus.mem_read        = 1'b0;
        bus.mem_to_reg      = 1'b0;
    endtask

    // Called at a negedge: r[dest] = r0 + val, committed at the next posedge.
    task automatic wr_reg(input logic [2:0] dest, input logic [7:0] val);
        idle();
        bus.alu_src        = 1'b1;
        bus.imm            = val;
        bus.reg_write_dest = dest;
        bus.reg_write_en   = 1'b1;
        @(negedge clk);
        idle();
    endtask

    task automatic alu_rr(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] op);
        idle();
        bus.reg_read_addr_1 = ra;
        bus.reg_read_addr_2 = rb;
        bus.alu_control     = op;
        #1;
    endtask

    task automatic alu_ri(input logic [2:0] ra, input logic [7:0] b, input logic [2:0] op);
        idle();
        bus.reg_read_addr_1 = ra;
        bus.alu_src         = 1'b1;
        bus.imm             = b;
        bus.alu_control     = op;
        #1;
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Put non-zero state in r5 and mem[2] so the mid-cycle reset has something to clear.
        wr_reg(3'd5, 8'h99);
        idle();
        bus.reg_read_addr_2 = 3'd5;
        bus.alu_src = 1'b1; bus.imm = 8'd2; bus.mem_write = 1'b1;
        @(negedge clk);
        alu_ri(3'd0, 8'd2, 3'b000);
        bus.mem_read = 1'b1; #1;
        check("pre_reset_mem2", bus.mem_read_data, 8'h99);

        // Asynchronous reset asserted away from any clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            alu_rr(3'(i), 3'(i), 3'b000);
            check($sformatf("rst_rd1_r%0d", i), bus.reg_read_data_1, 8'h00);
            check($sformatf("rst_rd2_r%0d", i), bus.reg_read_data_2, 8'h00);
        end
        for (int i = 0; i < 16; i++) begin
            alu_ri(3'd0, 8'(i), 3'b000);
            bus.mem_read = 1'b1; #1;
            check($sformatf("rst_mem_%0d", i), bus.mem_read_data, 8'h00);
        end
        alu_rr(3'd0, 3'd0, 3'b000);
        check("rst_zero", 8'(bus.zero), 8'h01);
        // Write attempted across a clock edge while reset is held must be ignored.
        alu_ri(3'd0, 8'h5A, 3'b000);
        bus.reg_write_dest = 3'd7; bus.reg_write_en = 1'b1;
        @(negedge clk);
        idle();
        rst = 1'b0;
        alu_rr(3'd7, 3'd0, 3'b000);
        check("rst_write_ignored_r7", bus.reg_read_data_1, 8'h00);

        @(negedge clk);
        wr_reg(3'd3, 8'h2A);
        alu_rr(3'd3, 3'd0, 3'b000);
        check("r3_readback", bus.reg_read_data_1, 8'h2A);

        @(negedge clk);
        wr_reg(3'd1, 8'hF0);
        wr_reg(3'd2, 8'h10);
        alu_rr(3'd1, 3'd2, 3'b000); check("add_wrap", bus.alu_result, 8'h00);
        check("add_zero", 8'(bus.zero), 8'h01);
        alu_rr(3'd1, 3'd2, 3'b001); check("sub", bus.alu_result, 8'hE0);
        check("sub_nonzero", 8'(bus.zero), 8'h00);
        alu_rr(3'd1, 3'd2, 3'b111); check("slt_false", bus.alu_result, 8'h00);
        alu_rr(3'd2, 3'd1, 3'b111); check("slt_true", bus.alu_result, 8'h01);
        alu_rr(3'd1, 3'd2, 3'b101); check("and", bus.alu_result, 8'h10);
        alu_rr(3'd1, 3'd2, 3'b110); check("or", bus.alu_result, 8'hF0);
        alu_rr(3'd1, 3'd2, 3'b010); check("not", bus.alu_result, 8'h0F);
        alu_rr(3'd2, 3'd1, 3'b001); check("sub_wrap", bus.alu_result, 8'h20);

        @(negedge clk);
        wr_reg(3'd7, 8'h01);
        wr_reg(3'd5, 8'h80);
        alu_ri(3'd7, 8'd7, 3'b011); check("shl7", bus.alu_result, 8'h80);
        alu_ri(3'd7, 8'd8, 3'b011); check("shl8", bus.alu_result, 8'h00);
        check("shl8_zero", 8'(bus.zero), 8'h01);
        alu_ri(3'd5, 8'd7, 3'b100); check("shr7", bus.alu_result, 8'h01);
        alu_ri(3'd5, 8'd8, 3'b100); check("shr8", bus.alu_result, 8'h00);
        alu_ri(3'd5, 8'hFF, 3'b011); check("shl_big", bus.alu_result, 8'h00);

        // Store r2=55 to addr 5; same-cycle load must return the old word.
        @(negedge clk);
        wr_reg(3'd2, 8'h55);
        idle();
        bus.reg_read_addr_2 = 3'd2;
        bus.alu_src = 1'b1; bus.imm = 8'd5;
        bus.mem_write = 1'b1; bus.mem_read = 1'b1; #1;
        check("store_old_word", bus.mem_read_data, 8'h00);
        @(negedge clk);
        idle();
        bus.alu_src = 1'b1; bus.imm = 8'd5;
        bus.mem_read = 1'b1; bus.mem_to_reg = 1'b1;
        bus.reg_write_dest = 3'd4; bus.reg_write_en = 1'b1; #1;
        check("load_wb", bus.reg_write_data, 8'h55);
        @(negedge clk);
        alu_rr(3'd4, 3'd0, 3'b000); check("r4_loaded", bus.reg_read_data_1, 8'h55);
        alu_ri(3'd0, 8'd21, 3'b000);
        bus.mem_read = 1'b1; #1;
        check("alias_load", bus.mem_read_data, 8'h55);
        bus.mem_read = 1'b0; #1;
        check("no_read_zero", bus.mem_read_data, 8'h00);
        check("wb_alu", bus.reg_write_data, 8'h15);

        // Same-edge write/read of r6: old value before the edge, new after.
        @(negedge clk);
        wr_reg(3'd6, 8'h11);
        idle();
        bus.reg_read_addr_2 = 3'd6;
        bus.alu_src = 1'b1; bus.imm = 8'h22;
        bus.reg_write_dest = 3'd6; bus.reg_write_en = 1'b1; #1;
        check("r6_before_edge", bus.reg_read_data_2, 8'h11);
        @(negedge clk);
        bus.reg_write_en = 1'b0; #1;
        check("r6_after_edge", bus.reg_read_data_2, 8'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
